// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   ls_op_e     - LSCtrl encodings; the extend stage uses the same values.
//   lsu_state_e - control FSM states.
//   FC_*        - faultCode values.
//   is_word_op  - true for LW/SW. These ops always use byte offset 0.
package lsu_pkg;

  typedef enum logic [2:0] {
    LS_LB  = 3'b000,
    LS_LH  = 3'b001,
    LS_LW  = 3'b010,
    LS_LBU = 3'b011,
    LS_LHU = 3'b100,
    LS_SB  = 3'b101,
    LS_SH  = 3'b110,
    LS_SW  = 3'b111
  } ls_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE,
    ST_ERR
  } lsu_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  function automatic logic is_word_op(input logic [2:0] op);
    return (op == LS_LW) || (op == LS_SW);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane steering for a single access.
//   ls_ctrl    in  3  : op encoding (ls_op_e)
//   addr_lo    in  2  : byte address bits [1:0]
//   store_data in  32 : store source, value in the low bits
//   be         out 4  : byte enables within the aligned word
//   wdata      out 32 : store data replicated across its lanes (0 for loads)
//   misalign   out 1  : access does not fit its natural alignment
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  ls_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    case (ls_op_e'(ls_ctrl))
      LS_LB, LS_LBU: be = 4'b0001 << addr_lo;
      LS_SB: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      LS_LH, LS_LHU: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      LS_SH: begin
        be       = 4'b0011 << {addr_lo[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      LS_LW: begin
        be       = 4'b1111;
        misalign = |addr_lo;
      end
      LS_SW: begin
        be       = 4'b1111;
        wdata    = store_data;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control FSM that sits between the pipeline and data memory.
//   Pipeline side : memOp, LSCtrl, addr, storeData in
//                   busy, done, loadData, fault, faultCode out
//   Memory side   : memReq, memWe, memAddr, memWData, memBe out
//                   memRData, memReady in
//   TIMEOUT       : number of ACCESS cycles without memReady before a timeout fault (2..255)
// Every output except busy comes straight from a flop.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memOp,
  input  logic [2:0]  LSCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] loadData,
  output logic        fault,
  output logic [1:0]  faultCode,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic [3:0]  memBe,
  input  logic [31:0] memRData,
  input  logic        memReady
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [1:0]  fcode_q, fcode_d;
  logic [31:0] ldata_q, ldata_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;

  lsu_lane u_lane (
    .ls_ctrl    (LSCtrl),
    .addr_lo    (addr[1:0]),
    .store_data (storeData),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .misalign   (lane_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    fcode_d     = FC_NONE;
    ldata_d     = ldata_q;
    case (state_q)
      ST_IDLE: begin
        if (memOp) begin
          if (lane_misalign) begin
            state_d = ST_ERR;
            fault_d = 1'b1;
            fcode_d = FC_MISALIGN;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = 8'd1;
            mem_req_d   = 1'b1;
            mem_we_d    = (LSCtrl >= LS_SB);
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
            off_d       = is_word_op(LSCtrl) ? 2'b00 : addr[1:0];
          end
        end
      end
      ST_ACCESS: begin
        // memReady is checked first, so it wins over a timeout on the same cycle.
        if (memReady) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (!mem_we_q) ldata_d = memRData >> {off_q, 3'b000};
        end else if (cnt_q == TO_LIM) begin
          state_d   = ST_ERR;
          fault_d   = 1'b1;
          fcode_d   = FC_TIMEOUT;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // DONE and ERR each last exactly one cycle. A memOp seen here is
      // ignored; it is accepted on the next IDLE cycle.
      ST_DONE, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'b0000;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fcode_q     <= FC_NONE;
      ldata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      fcode_q     <= fcode_d;
      ldata_q     <= ldata_d;
    end
  end

  // busy stays low in DONE and ERR, so the pipeline advances exactly once per op.
  assign busy      = ((state_q == ST_IDLE) && memOp) || (state_q == ST_ACCESS);
  assign done      = done_q;
  assign fault     = fault_q;
  assign faultCode = fcode_q;
  assign loadData  = ldata_q;
  assign memReq    = mem_req_q;
  assign memWe     = mem_we_q;
  assign memAddr   = mem_addr_q;
  assign memWData  = mem_wdata_q;
  assign memBe     = mem_be_q;

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max ACCESS cycles waiting for memReady before fault (range 2..255).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port: memOp  in  1  pipeline load/store request, held until busy low.
REQ-005 SHALL have port: LSCtrl  in  3  op: LB 000, LH 001, LW 010, LBU 011, LHU 100, SB 101, SH 110, SW 111.
REQ-006 SHALL have port: addr  in  32  byte address.
REQ-007 SHALL have port: storeData  in  32  store source, value in low bits.
REQ-008 SHALL have port: busy  out  1  pipeline stall.
REQ-009 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port: loadData  out  32  lane-aligned read data (byte/half in low bits), unextended, for the extend stage.
REQ-011 SHALL have port: fault  out  1  one-cycle error pulse.
REQ-012 SHALL have port: faultCode  out  2  01 misaligned, 10 timeout, else 00.
REQ-013 SHALL have ports: memReq out 1, memWe out 1, memAddr out 32, memWData out 32, memBe out 4, memRData in 32, memReady in 1: data-memory handshake.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE, ERR.
REQ-015 IDLE with memOp=1 and misaligned op SHALL go to ERR, no memReq.
REQ-016 Misaligned SHALL be: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; byte ops never.
REQ-017 IDLE with memOp=1 and aligned op SHALL register memAddr={addr[31:2],2'b00}, memWe=(LSCtrl>=101), memBe, memWData, byte offset, and go to ACCESS.
REQ-018 memBe SHALL be: byte ops 0001<<addr[1:0]; half ops 0011<<{addr[1],1'b0}; LW/SW 1111.
REQ-019 memWData SHALL replicate storeData[7:0] x4 (SB), storeData[15:0] x2 (SH), storeData (SW); 0 for loads.
REQ-020 memReq SHALL be high exactly while in ACCESS; address, be, data, we stable throughout.
REQ-021 ACCESS with memReady=1 SHALL go to DONE; loads capture loadData = memRData >> (8*offset), offset forced 0 for word ops.
REQ-022 ACCESS cycle counter SHALL start at 1 on entry; reaching TIMEOUT with memReady=0 SHALL go to ERR, faultCode 10.
REQ-023 memReady and timeout in same cycle: memReady SHALL win.
REQ-024 DONE SHALL assert done=1 one cycle, then IDLE; loadData holds until next load completes.
REQ-025 ERR SHALL assert fault=1 with faultCode one cycle, then IDLE; loadData unchanged.
REQ-026 busy SHALL be (IDLE and memOp) or ACCESS; low in DONE/ERR so pipeline advances exactly once.
REQ-027 memOp in DONE/ERR SHALL be ignored that cycle; accepted next IDLE.
REQ-028 Latency: acceptance edge N, memReq from N+1; memReady first sampled at edge N+1 -> done high N+1..N+2 (2 cycles zero-wait).
REQ-029 memReady outside ACCESS SHALL be ignored.

Reset
REQ-030 rst_n=0 at clock edge SHALL force IDLE, counter 0, all outputs 0 (loadData 0, faultCode 00), from any state.
REQ-031 Reset during ACCESS SHALL drop memReq next cycle with no done/fault.

Structure
REQ-032 Package lsu_pkg SHALL hold LSCtrl encodings (shared with extend), FSM state enum, faultCode constants.
REQ-033 Combinational sub-module lsu_lane SHALL compute memBe, memWData, misalign from LSCtrl, addr[1:0], storeData; lsu_ctrl instantiates it once.
REQ-034 All outputs except busy SHALL be registered.

Verification
REQ-035 SW addr 0x100, data 0xDEADBEEF, memReady on first ACCESS cycle -> memAddr 0x100, memBe 1111, memWe 1, done 2 cycles after accept.
REQ-036 LB addr 0x203, memRData 0x80AABBCC -> memBe 1000, loadData 0x00000080.
REQ-037 SH addr 0x12, storeData 0x0000CAFE -> memWData 0xCAFECAFE, memBe 1100.
REQ-038 LW addr 0x102 -> fault, faultCode 01, memReq never high.
REQ-039 TIMEOUT=4, memReady held 0 -> memReq high 4 cycles, then fault, faultCode 10; memReady=1 on 4th cycle instead -> done, no fault.
REQ-040 rst_n=0 in 2nd ACCESS cycle -> memReq 0 next cycle, busy 0, no done/fault.
